multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I core. Decodes the opcode held in the instruction register and sequences the shared datapath over several cycles: one ALU, one unified memory port, the register file and the immediate extension unit. Drives the immediate-format select, ALU operand muxes, ALU operation, result mux and all write enables. Stalls on a memory ready handshake.

---
 rtl/multicycle_controller.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the multicycle RV32I core.
// Sequences the shared ALU, unified memory port, register file and immediate
// unit over several cycles per instruction, stalling on mem_ready.
// Optional feature: define ILLEGAL_OPCODE_TRAP_EN to trap unknown opcodes and
// unsupported ALU funct3 values into a sticky HALT state (illegal_instr=1).
// Without the macro unknown opcodes behave as NOPs and illegal_instr is 0.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
`ifdef ILLEGAL_OPCODE_TRAP_EN
    , S_HALT
`endif
  } state_t;

  state_t state_r;
  state_t next_state_s;
  state_t dec_state_s;
  logic   ir_we_s;
  logic   pc_we_s;
  logic   mem_we_s;
  logic   reg_we_s;

  // ALU operation from funct3; only R-type honours funct7_5 for sub.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7_5,
                                            input logic       is_rtype);
    logic [2:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: begin
        if (is_rtype && f7_5) op = ALU_SUB;
        else                  op = ALU_ADD;
      end
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

`ifdef ILLEGAL_OPCODE_TRAP_EN
  // funct3 values the ALU decode actually implements.
  function automatic logic f3_supported(input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b010, 3'b100, 3'b110, 3'b111: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_r <= S_FETCH;
    else       state_r <= next_state_s;
  end

  // Next-state logic: memory states hold until mem_ready, HALT holds until reset.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) next_state_s = S_DECODE;
        else           next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_R:         next_state_s = S_EXECR;
          OP_I:         next_state_s = S_EXECI;
          OP_BR:        next_state_s = S_BRANCH;
          OP_JAL:       next_state_s = S_JAL;
`ifdef ILLEGAL_OPCODE_TRAP_EN
          default:      next_state_s = S_HALT;
`else
          default:      next_state_s = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_SW) next_state_s = S_MEMWRITE;
        else                 next_state_s = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (mem_ready) next_state_s = S_MEMWB;
        else           next_state_s = S_MEMREAD;
      end
      S_MEMWB: next_state_s = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) next_state_s = S_FETCH;
        else           next_state_s = S_MEMWRITE;
      end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_EXECR, S_EXECI: begin
        if (f3_supported(funct3)) next_state_s = S_ALUWB;
        else                      next_state_s = S_HALT;
      end
      S_HALT: next_state_s = S_HALT;
`else
      S_EXECR, S_EXECI: next_state_s = S_ALUWB;
`endif
      S_ALUWB:  next_state_s = S_FETCH;
      S_BRANCH: next_state_s = S_FETCH;
      S_JAL:    next_state_s = S_ALUWB;
      default:  next_state_s = S_FETCH;
    endcase
  end

  // Output decode; while reset is high the outputs look like FETCH.
  always_comb begin
    dec_state_s   = reset ? S_FETCH : state_r;
    imm_src       = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = ALU_ADD;
    result_src    = 2'b00;
    adr_src       = 1'b0;
    ir_we_s       = 1'b0;
    pc_we_s       = 1'b0;
    mem_we_s      = 1'b0;
    reg_we_s      = 1'b0;
    illegal_instr = 1'b0;
    case (dec_state_s)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_we_s    = mem_ready;
        pc_we_s    = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? 2'b11 : 2'b10;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_SW) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_we_s   = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src  = 1'b1;
        mem_we_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_decode(funct3, funct7_5, 1'b1);
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_decode(funct3, funct7_5, 1'b0);
      end
      S_ALUWB: begin
        reg_we_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        if (funct3 == 3'b000)      pc_we_s = zero;
        else if (funct3 == 3'b001) pc_we_s = ~zero;
        else                       pc_we_s = 1'b0;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_we_s   = 1'b1;
      end
`ifdef ILLEGAL_OPCODE_TRAP_EN
      S_HALT: begin
        illegal_instr = 1'b1;
      end
`endif
      default: begin
        alu_src_b = 2'b10;
      end
    endcase
  end

  // No write enable may fire while reset is asserted.
  always_comb begin
    ir_write  = ir_we_s  & ~reset;
    pc_write  = pc_we_s  & ~reset;
    mem_write = mem_we_s & ~reset;
    reg_write = reg_we_s & ~reset;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed test-plan sequences followed by random
// instruction streams, all checked every cycle against a step-list model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready, funct7_5;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic       adr_src, ir_write, pc_write, mem_write, reg_write, illegal_instr;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
    .imm_src(imm_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .result_src(result_src), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .mem_write(mem_write),
    .reg_write(reg_write), .illegal_instr(illegal_instr)
  );

  // One cycle of expected behaviour; an instruction is a list of these.
  typedef struct packed {
    logic [1:0] imm, a, b, res;
    logic [2:0] alu;
    logic adr, fetch, pcw, pcw_br, memw, regw, stall, halt;
  } step_t;

  int tests = 0;
  int fails = 0;
  step_t q[$];
  logic [6:0] ir_op = 7'd0, nx_op = 7'd0;
  logic [2:0] ir_f3 = 3'd0, nx_f3 = 3'd0;
  logic       ir_f7 = 1'b0, nx_f7 = 1'b0;

  function automatic step_t mk(logic [1:0] imm, logic [1:0] a, logic [1:0] b,
                               logic [1:0] res, logic [2:0] alu, logic adr);
    step_t s;
    s = '0;
    s.imm = imm; s.a = a; s.b = b; s.res = res; s.alu = alu; s.adr = adr;
    return s;
  endfunction

  function automatic step_t fetch_step();
    step_t s;
    s = mk(2'b00, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
    s.fetch = 1'b1; s.stall = 1'b1;
    return s;
  endfunction

  function automatic step_t halt_step();
    step_t s;
    s = '0; s.halt = 1'b1;
    return s;
  endfunction

  function automatic step_t wb_step(logic [1:0] res);
    step_t s;
    s = mk(2'b00, 2'b00, 2'b00, res, 3'b000, 1'b0);
    s.regw = 1'b1;
    return s;
  endfunction

  // RISC-V meaning of funct3: add/sub, slt, xor, or, and; everything else adds.
  function automatic logic [2:0] alu_for(logic [2:0] f3, logic f7, logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic f3_ok(logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b100) ||
           (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Append the post-fetch steps of the instruction now in the IR.
  function automatic void plan();
    step_t s;
    q.push_back(mk((ir_op == 7'b1101111) ? 2'b11 : 2'b10, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0));
    case (ir_op)
      7'b0000011: begin
        q.push_back(mk(2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        s = mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1); s.stall = 1'b1;
        q.push_back(s);
        q.push_back(wb_step(2'b01));
      end
      7'b0100011: begin
        q.push_back(mk(2'b01, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        s = mk(2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1); s.stall = 1'b1; s.memw = 1'b1;
        q.push_back(s);
      end
      7'b0110011, 7'b0010011: begin
        q.push_back(mk(2'b00, 2'b10, (ir_op == 7'b0010011) ? 2'b01 : 2'b00, 2'b00,
                       alu_for(ir_f3, ir_f7, ir_op == 7'b0110011), 1'b0));
`ifdef ILLEGAL_OPCODE_TRAP_EN
        if (!f3_ok(ir_f3)) q.push_back(halt_step());
        else               q.push_back(wb_step(2'b00));
`else
        q.push_back(wb_step(2'b00));
`endif
      end
      7'b1100011: begin
        s = mk(2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0); s.pcw_br = 1'b1;
        q.push_back(s);
      end
      7'b1101111: begin
        s = mk(2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0); s.pcw = 1'b1;
        q.push_back(s);
        q.push_back(wb_step(2'b00));
      end
      default: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
        q.push_back(halt_step());
`endif
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model's current step.
  task automatic compare_model();
    step_t e;
    logic brc, rdy_ok;
    e = (reset || q.size() == 0) ? fetch_step() : q[0];
    brc = (ir_f3 == 3'b000) ? zero : ((ir_f3 == 3'b001) ? ~zero : 1'b0);
    rdy_ok = e.fetch & mem_ready;
    check("m_imm_src", imm_src, e.imm);
    check("m_alu_src_a", alu_src_a, e.a);
    check("m_alu_src_b", alu_src_b, e.b);
    check("m_alu_control", alu_control, e.alu);
    check("m_result_src", result_src, e.res);
    check("m_adr_src", adr_src, e.adr);
    check("m_ir_write", ir_write, !reset && rdy_ok);
    check("m_pc_write", pc_write, !reset && (rdy_ok || e.pcw || (e.pcw_br && brc)));
    check("m_mem_write", mem_write, !reset && e.memw);
    check("m_reg_write", reg_write, !reset && e.regw);
    check("m_illegal", illegal_instr, !reset && e.halt);
  endtask

  task automatic settle(input logic rst, input logic rdy, input logic z);
    reset = rst; mem_ready = rdy; zero = z;
    @(negedge clk);
    compare_model();
  endtask

  // Clock edge: advance the model, then present a freshly loaded IR.
  task automatic advance();
    step_t h;
    @(posedge clk);
    if (reset || q.size() == 0) begin
      q.delete();
      q.push_back(fetch_step());
    end else begin
      h = q[0];
      if (!(h.halt || (h.stall && !mem_ready))) begin
        void'(q.pop_front());
        if (h.fetch) begin
          ir_op = nx_op; ir_f3 = nx_f3; ir_f7 = nx_f7;
          plan();
        end
        if (q.size() == 0) q.push_back(fetch_step());
      end
    end
    #1;
    opcode = ir_op; funct3 = ir_f3; funct7_5 = ir_f7;
  endtask

  task automatic set_next(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    nx_op = op; nx_f3 = f3; nx_f7 = f7;
  endtask

  task automatic cyc(input logic rdy, input logic z);
    settle(1'b0, rdy, z);
    advance();
  endtask

  logic [6:0] op_tab [8];

  // Directed test-plan sequences, then a random instruction stream.
  initial begin
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
    settle(1'b1, 1'b1, 1'b0); check("rst_irw", ir_write, 8'd0); check("rst_b", alu_src_b, 8'd2);
    advance();
    settle(1'b1, 1'b1, 1'b0); advance();

    // R-type sub: 4 cycles
    set_next(7'b0110011, 3'b000, 1'b1);
    settle(1'b0, 1'b1, 1'b0); check("sub_fetch_irw", ir_write, 8'd1); advance();
    settle(1'b0, 1'b1, 1'b0); check("sub_dec_a", alu_src_a, 8'd1); advance();
    settle(1'b0, 1'b1, 1'b0); check("sub_execr_alu", alu_control, 8'd1); advance();
    settle(1'b0, 1'b1, 1'b0); check("sub_aluwb_regw", reg_write, 8'd1); advance();

    // lw with two stall cycles in MEMREAD: 7 cycles
    set_next(7'b0000011, 3'b010, 1'b0);
    settle(1'b0, 1'b1, 1'b0); check("lw_fetch_irw", ir_write, 8'd1); advance();
    cyc(1'b1, 1'b0);
    settle(1'b0, 1'b1, 1'b0); check("lw_memadr_imm", imm_src, 8'd0);
    check("lw_memadr_a", alu_src_a, 8'd2); check("lw_memadr_b", alu_src_b, 8'd1); advance();
    for (int i = 0; i < 3; i++) begin
      settle(1'b0, (i == 2) ? 1'b1 : 1'b0, 1'b0); check("lw_memread_adr", adr_src, 8'd1); advance();
    end
    settle(1'b0, 1'b1, 1'b0); check("lw_memwb_regw", reg_write, 8'd1);
    check("lw_memwb_res", result_src, 8'd1); advance();

    // sw
    set_next(7'b0100011, 3'b010, 1'b0);
    settle(1'b0, 1'b1, 1'b0); check("sw_fetch_irw", ir_write, 8'd1); advance();
    cyc(1'b1, 1'b0);
    settle(1'b0, 1'b1, 1'b0); check("sw_memadr_imm", imm_src, 8'd1); advance();
    settle(1'b0, 1'b1, 1'b0); check("sw_memw", mem_write, 8'd1); check("sw_regw", reg_write, 8'd0); advance();

    // beq z=1, beq z=0, bne z=0 -> pc_write 1,0,1
    for (int k = 0; k < 3; k++) begin
      set_next(7'b1100011, (k == 2) ? 3'b001 : 3'b000, 1'b0);
      settle(1'b0, 1'b1, 1'b0); check("br_fetch_memw", mem_write, 8'd0); advance();
      settle(1'b0, 1'b1, 1'b0); check("br_dec_imm", imm_src, 8'd2); advance();
      settle(1'b0, 1'b1, (k == 0) ? 1'b1 : 1'b0);
      check("br_pcw", pc_write, (k == 1) ? 8'd0 : 8'd1); advance();
    end

    // jal
    set_next(7'b1101111, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    settle(1'b0, 1'b1, 1'b0); check("jal_dec_imm", imm_src, 8'd3); advance();
    settle(1'b0, 1'b1, 1'b0); check("jal_pcw", pc_write, 8'd1);
    check("jal_a", alu_src_a, 8'd1); check("jal_b", alu_src_b, 8'd2); advance();
    settle(1'b0, 1'b1, 1'b0); check("jal_wb_regw", reg_write, 8'd1); advance();

    // unknown opcode 1111111
    set_next(7'b1111111, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
`ifdef ILLEGAL_OPCODE_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      settle(1'b0, 1'b1, 1'b0); check("halt_ill", illegal_instr, 8'd1);
      check("halt_irw", ir_write, 8'd0); advance();
    end
    settle(1'b1, 1'b1, 1'b0); check("halt_rst_ill", illegal_instr, 8'd0); advance();
`else
    settle(1'b0, 1'b0, 1'b0); check("nop_fetch_b", alu_src_b, 8'd2);
    check("nop_irw", ir_write, 8'd0); check("nop_ill", illegal_instr, 8'd0); advance();
`endif

    // reset mid-MEMREAD stall
    set_next(7'b0000011, 3'b000, 1'b0);
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    settle(1'b0, 1'b0, 1'b0); check("rs_memread_adr", adr_src, 8'd1); advance();
    settle(1'b1, 1'b0, 1'b0); check("rs_regw", reg_write, 8'd0);
    check("rs_adr", adr_src, 8'd0); advance();
    settle(1'b0, 1'b1, 1'b0); check("rs_fetch_irw", ir_write, 8'd1);
    check("rs_fetch_b", alu_src_b, 8'd2); advance();

    // random instruction stream
    op_tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
               7'b1100011, 7'b1101111, 7'b1111111, 7'b0000000};
    for (int n = 0; n < 4000; n++) begin
      nx_op = op_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) nx_op = 7'($urandom_range(0, 127));
      nx_f3 = 3'($urandom_range(0, 7));
      nx_f7 = 1'($urandom_range(0, 1));
      settle(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
             1'($urandom_range(0, 1)));
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
